// File: rtl/net_res_pkg.sv
// Shared types and helpers for the multi-driver net resolver.
// Exports res_mode_e, res_bit_t, out_state_e and res_onehot_ok().
package net_res_pkg;

    typedef enum logic [2:0] {
        RES_TRI,
        RES_WOR,
        RES_WAND,
        RES_TRI0,
        RES_TRI1
    } res_mode_e;

    typedef struct packed {
        logic val;
        logic x;
        logic z;
    } res_bit_t;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_e;

    // x and z never coexist, and val is 0 whenever x or z is set.
    function automatic logic res_onehot_ok(res_bit_t b);
        return !(b.x && b.z) && !((b.x || b.z) && b.val);
    endfunction

endpackage

// File: rtl/net_res_bit.sv
// Combinational resolution of one net bit over N_DRV drivers.
// Ports: en/val per driver in, res (val/x/z planes) out.
module net_res_bit
    import net_res_pkg::*;
#(
    parameter int        N_DRV = 4,
    parameter res_mode_e MODE  = RES_TRI
) (
    input  logic [N_DRV-1:0] en,
    input  logic [N_DRV-1:0] val,
    output res_bit_t         res
);

    logic any_en;
    logic any1;
    logic any0;

    assign any_en = |en;
    assign any1   = |(en & val);
    assign any0   = |(en & ~val);

    always_comb begin
        res = '0;
        if (!any_en) begin
            case (MODE)
                RES_TRI0: res.val = 1'b0;
                RES_TRI1: res.val = 1'b1;
                default:  res.z   = 1'b1;
            endcase
        end else begin
            case (MODE)
                RES_WOR:  res.val = any1;
                RES_WAND: res.val = !any0;
                default: begin
                    // Disagreeing enabled drivers are contention.
                    res.x   = any1 && any0;
                    res.val = any1 && !any0;
                end
            endcase
        end
    end

endmodule

// File: rtl/net_resolver.sv
// Registered multi-driver net resolver with valid/ready output and
// conflict statistics. Ports: clk, rst_n, in_valid/in_ready,
// drv_en/drv_val (driver d at [d*WIDTH +: WIDTH]),
// out_valid/out_ready, out_val/out_x/out_z, cnt_clr,
// conflict_cnt, first_vld, first_bit.
module net_resolver
    import net_res_pkg::*;
#(
    parameter int        WIDTH = 8,
    parameter int        N_DRV = 4,
    parameter res_mode_e MODE  = RES_TRI,
    parameter int        CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DRV*WIDTH-1:0]   drv_en,
    input  logic [N_DRV*WIDTH-1:0]   drv_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_val,
    output logic [WIDTH-1:0]         out_x,
    output logic [WIDTH-1:0]         out_z,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         conflict_cnt,
    output logic                     first_vld,
    output logic [$clog2(WIDTH)-1:0] first_bit
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] nxt_val;
    logic [WIDTH-1:0] nxt_x;
    logic [WIDTH-1:0] nxt_z;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [N_DRV-1:0] en_b;
        logic [N_DRV-1:0] val_b;
        res_bit_t         res_b;

        always_comb begin
            en_b  = '0;
            val_b = '0;
            for (int d = 0; d < N_DRV; d++) begin
                en_b[d]  = drv_en[d*WIDTH + b];
                val_b[d] = drv_val[d*WIDTH + b];
            end
        end

        net_res_bit #(
            .N_DRV (N_DRV),
            .MODE  (MODE)
        ) u_bit (
            .en  (en_b),
            .val (val_b),
            .res (res_b)
        );

        assign nxt_val[b] = res_b.val;
        assign nxt_x[b]   = res_b.x;
        assign nxt_z[b]   = res_b.z;
    end

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic [IDX_W-1:0] fb_q, fb_d;
    logic [IDX_W-1:0] x_idx;
    logic             accept;

    assign out_valid    = (state_q == ST_FULL);
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign out_val      = val_q;
    assign out_x        = x_q;
    assign out_z        = z_q;
    assign conflict_cnt = cnt_q;
    assign first_vld    = fv_q;
    assign first_bit    = fb_q;

    // Descending scan so the lowest set x bit wins.
    always_comb begin
        x_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (nxt_x[i]) begin
                x_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        x_d     = x_q;
        z_d     = z_q;
        if (accept) begin
            state_d = ST_FULL;
            val_d   = nxt_val;
            x_d     = nxt_x;
            z_d     = nxt_z;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Clear lands first so a same-cycle conflict is counted afresh.
    always_comb begin
        cnt_d = cnt_clr ? '0 : cnt_q;
        fv_d  = cnt_clr ? 1'b0 : fv_q;
        fb_d  = fb_q;
        if (accept && (|nxt_x)) begin
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
            if (!fv_d) begin
                fv_d = 1'b1;
                fb_d = x_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            val_q   <= '0;
            x_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            x_q     <= x_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            fb_q    <= fb_d;
        end
    end

    logic     planes_ok;
    res_bit_t rb;

    always_comb begin
        planes_ok = 1'b1;
        rb        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rb.val = val_q[i];
            rb.x   = x_q[i];
            rb.z   = z_q[i];
            if (!res_onehot_ok(rb)) begin
                planes_ok = 1'b0;
            end
        end
    end

    a_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) planes_ok
    );

    a_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable({val_q, x_q, z_q})
    );

endmodule

// File: tb/tb_net_resolver.sv
// Directed bench for net_resolver: one DUT per resolution kind plus a
// 2-bit-counter instance, all fed from the same driver stimulus.
module tb_net_resolver;
    import net_res_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       cnt_clr;
    logic [7:0] drv_en;
    logic [7:0] drv_val;

    // index: 0 TRI, 1 TRI0, 2 TRI1, 3 WOR, 4 WAND, 5 TRI with CNT_W=2
    logic       rdy [6];
    logic       ov  [6];
    logic [3:0] oval[6];
    logic [3:0] ox  [6];
    logic [3:0] oz  [6];
    logic       fv  [6];
    logic [1:0] fb  [6];
    logic [7:0] cnt [5];
    logic [1:0] sat_cnt;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    net_resolver #(.WIDTH(4), .N_DRV(2), .MODE(RES_TRI), .CNT_W(8)) u_tri (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .drv_en(drv_en), .drv_val(drv_val), .out_valid(ov[0]),
        .out_ready(out_ready), .out_val(oval[0]), .out_x(ox[0]),
        .out_z(oz[0]), .cnt_clr(cnt_clr), .conflict_cnt(cnt[0]),
        .first_vld(fv[0]), .first_bit(fb[0])
    );

    net_resolver #(.WIDTH(4), .N_DRV(2), .MODE(RES_TRI0), .CNT_W(8)) u_tri0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .drv_en(drv_en), .drv_val(drv_val), .out_valid(ov[1]),
        .out_ready(out_ready), .out_val(oval[1]), .out_x(ox[1]),
        .out_z(oz[1]), .cnt_clr(cnt_clr), .conflict_cnt(cnt[1]),
        .first_vld(fv[1]), .first_bit(fb[1])
    );

    net_resolver #(.WIDTH(4), .N_DRV(2), .MODE(RES_TRI1), .CNT_W(8)) u_tri1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .drv_en(drv_en), .drv_val(drv_val), .out_valid(ov[2]),
        .out_ready(out_ready), .out_val(oval[2]), .out_x(ox[2]),
        .out_z(oz[2]), .cnt_clr(cnt_clr), .conflict_cnt(cnt[2]),
        .first_vld(fv[2]), .first_bit(fb[2])
    );

    net_resolver #(.WIDTH(4), .N_DRV(2), .MODE(RES_WOR), .CNT_W(8)) u_wor (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .drv_en(drv_en), .drv_val(drv_val), .out_valid(ov[3]),
        .out_ready(out_ready), .out_val(oval[3]), .out_x(ox[3]),
        .out_z(oz[3]), .cnt_clr(cnt_clr), .conflict_cnt(cnt[3]),
        .first_vld(fv[3]), .first_bit(fb[3])
    );

    net_resolver #(.WIDTH(4), .N_DRV(2), .MODE(RES_WAND), .CNT_W(8)) u_wand (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]),
        .drv_en(drv_en), .drv_val(drv_val), .out_valid(ov[4]),
        .out_ready(out_ready), .out_val(oval[4]), .out_x(ox[4]),
        .out_z(oz[4]), .cnt_clr(cnt_clr), .conflict_cnt(cnt[4]),
        .first_vld(fv[4]), .first_bit(fb[4])
    );

    net_resolver #(.WIDTH(4), .N_DRV(2), .MODE(RES_TRI), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[5]),
        .drv_en(drv_en), .drv_val(drv_val), .out_valid(ov[5]),
        .out_ready(out_ready), .out_val(oval[5]), .out_x(ox[5]),
        .out_z(oz[5]), .cnt_clr(cnt_clr), .conflict_cnt(sat_cnt),
        .first_vld(fv[5]), .first_bit(fb[5])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        drv_en    = 8'h00;
        drv_val   = 8'h00;
        #1 rst_n = 1'b0;
        step();
        step();
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b exp=0", ov[0]); end
        total++; if (oval[0] !== 4'b0000) begin bad++; $display("FAIL rst_val got=%b exp=0000", oval[0]); end
        total++; if (ox[0] !== 4'b0000 || oz[0] !== 4'b0000) begin bad++; $display("FAIL rst_xz got=%b/%b exp=0000/0000", ox[0], oz[0]); end
        total++; if (cnt[0] !== 8'd0 || fv[0] !== 1'b0 || fb[0] !== 2'd0) begin bad++; $display("FAIL rst_stats got=%0d/%b/%0d exp=0/0/0", cnt[0], fv[0], fb[0]); end
        total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b exp=1", rdy[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_s1_single();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drv_en    = {4'b0000, 4'b1111};
        drv_val   = {4'b0000, 4'b1010};
        step();
        total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL s1_ov got=%b exp=1", ov[0]); end
        total++; if (oval[0] !== 4'b1010) begin bad++; $display("FAIL s1_val got=%b exp=1010", oval[0]); end
        total++; if (ox[0] !== 4'b0000 || oz[0] !== 4'b0000) begin bad++; $display("FAIL s1_xz got=%b/%b exp=0000/0000", ox[0], oz[0]); end
        total++; if (cnt[0] !== 8'd0 || fv[0] !== 1'b0) begin bad++; $display("FAIL s1_cnt got=%0d/%b exp=0/0", cnt[0], fv[0]); end
    endtask

    task automatic test_s2_conflict();
        drv_en  = {4'b0011, 4'b0011};
        drv_val = {4'b0011, 4'b0001};
        step();
        total++; if (oval[0] !== 4'b0001) begin bad++; $display("FAIL s2_tri_val got=%b exp=0001", oval[0]); end
        total++; if (ox[0] !== 4'b0010) begin bad++; $display("FAIL s2_tri_x got=%b exp=0010", ox[0]); end
        total++; if (oz[0] !== 4'b1100) begin bad++; $display("FAIL s2_tri_z got=%b exp=1100", oz[0]); end
        total++; if (cnt[0] !== 8'd1 || fv[0] !== 1'b1 || fb[0] !== 2'd1) begin bad++; $display("FAIL s2_stats got=%0d/%b/%0d exp=1/1/1", cnt[0], fv[0], fb[0]); end
        total++; if (oval[1] !== 4'b0001 || oz[1] !== 4'b0000) begin bad++; $display("FAIL s2_tri0 got=%b/%b exp=0001/0000", oval[1], oz[1]); end
        total++; if (oval[2] !== 4'b1101 || ox[2] !== 4'b0010) begin bad++; $display("FAIL s2_tri1 got=%b/%b exp=1101/0010", oval[2], ox[2]); end
        total++; if (oval[3] !== 4'b0011 || ox[3] !== 4'b0000 || oz[3] !== 4'b1100) begin bad++; $display("FAIL s2_wor got=%b/%b/%b exp=0011/0000/1100", oval[3], ox[3], oz[3]); end
        total++; if (oval[4] !== 4'b0001 || cnt[4] !== 8'd0) begin bad++; $display("FAIL s2_wand got=%b/%0d exp=0001/0", oval[4], cnt[4]); end
    endtask

    task automatic test_s3_undriven();
        drv_en  = 8'h00;
        drv_val = 8'hFF;
        step();
        total++; if (oval[1] !== 4'b0000 || oz[1] !== 4'b0000 || ox[1] !== 4'b0000) begin bad++; $display("FAIL s3_tri0 got=%b/%b/%b exp=0000/0000/0000", oval[1], ox[1], oz[1]); end
        total++; if (oval[2] !== 4'b1111 || oz[2] !== 4'b0000) begin bad++; $display("FAIL s3_tri1 got=%b/%b exp=1111/0000", oval[2], oz[2]); end
        total++; if (oval[3] !== 4'b0000 || oz[3] !== 4'b1111) begin bad++; $display("FAIL s3_wor got=%b/%b exp=0000/1111", oval[3], oz[3]); end
        total++; if (oval[0] !== 4'b0000 || oz[0] !== 4'b1111 || cnt[0] !== 8'd1) begin bad++; $display("FAIL s3_tri got=%b/%b/%0d exp=0000/1111/1", oval[0], oz[0], cnt[0]); end
    endtask

    task automatic test_s4_wired();
        drv_en  = 8'hFF;
        drv_val = {4'b1010, 4'b1100};
        step();
        total++; if (oval[3] !== 4'b1110 || ox[3] !== 4'b0000) begin bad++; $display("FAIL s4_wor got=%b/%b exp=1110/0000", oval[3], ox[3]); end
        total++; if (oval[4] !== 4'b1000 || ox[4] !== 4'b0000) begin bad++; $display("FAIL s4_wand got=%b/%b exp=1000/0000", oval[4], ox[4]); end
        total++; if (oval[0] !== 4'b1000 || ox[0] !== 4'b0110) begin bad++; $display("FAIL s4_tri got=%b/%b exp=1000/0110", oval[0], ox[0]); end
        total++; if (cnt[0] !== 8'd2 || fb[0] !== 2'd1) begin bad++; $display("FAIL s4_stats got=%0d/%0d exp=2/1", cnt[0], fb[0]); end
    endtask

    task automatic test_backpressure();
        drv_en  = {4'b0000, 4'b1111};
        drv_val = {4'b0000, 4'b1010};
        step();
        out_ready = 1'b0;
        drv_en    = 8'hFF;
        drv_val   = {4'b1010, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL bp_rdy%0d got=%b exp=0", i, rdy[0]); end
            total++; if (oval[0] !== 4'b1010 || ox[0] !== 4'b0000 || ov[0] !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%b/%b/%b exp=1010/0000/1", i, oval[0], ox[0], ov[0]); end
            total++; if (cnt[0] !== 8'd2) begin bad++; $display("FAIL bp_cnt%0d got=%0d exp=2", i, cnt[0]); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL bp_rdy_comb got=%b exp=1", rdy[0]); end
        step();
        total++; if (oval[0] !== 4'b1000 || ox[0] !== 4'b0110 || ov[0] !== 1'b1) begin bad++; $display("FAIL bp_swap got=%b/%b/%b exp=1000/0110/1", oval[0], ox[0], ov[0]); end
        total++; if (cnt[0] !== 8'd3) begin bad++; $display("FAIL bp_swap_cnt got=%0d exp=3", cnt[0]); end
        in_valid = 1'b0;
        step();
        total++; if (ov[0] !== 1'b0 || cnt[0] !== 8'd3) begin bad++; $display("FAIL drain got=%b/%0d exp=0/3", ov[0], cnt[0]); end
    endtask

    task automatic test_clear();
        cnt_clr  = 1'b1;
        in_valid = 1'b1;
        drv_en   = 8'hFF;
        drv_val  = {4'b0100, 4'b0000};
        step();
        total++; if (cnt[0] !== 8'd1 || fv[0] !== 1'b1 || fb[0] !== 2'd2) begin bad++; $display("FAIL clr_hit got=%0d/%b/%0d exp=1/1/2", cnt[0], fv[0], fb[0]); end
        total++; if (ox[0] !== 4'b0100 || oval[0] !== 4'b0000) begin bad++; $display("FAIL clr_res got=%b/%b exp=0100/0000", ox[0], oval[0]); end
        total++; if (sat_cnt !== 2'd1) begin bad++; $display("FAIL clr_sat got=%0d exp=1", sat_cnt); end
        in_valid = 1'b0;
        step();
        total++; if (cnt[0] !== 8'd0 || fv[0] !== 1'b0) begin bad++; $display("FAIL clr_only got=%0d/%b exp=0/0", cnt[0], fv[0]); end
        cnt_clr = 1'b0;
    endtask

    task automatic test_saturate_reset();
        int exp_cnt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drv_en    = {4'b0011, 4'b0011};
        drv_val   = {4'b0011, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            step();
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            total++; if (sat_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, sat_cnt, exp_cnt); end
            total++; if (ov[5] !== 1'b1 || rdy[5] !== 1'b1) begin bad++; $display("FAIL sat_flow%0d got=%b/%b exp=1/1", i, ov[5], rdy[5]); end
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ov[5] !== 1'b0 || sat_cnt !== 2'd0 || fv[5] !== 1'b0) begin bad++; $display("FAIL arst_sat got=%b/%0d/%b exp=0/0/0", ov[5], sat_cnt, fv[5]); end
        total++; if (oval[5] !== 4'b0000 || ox[5] !== 4'b0000 || oz[5] !== 4'b0000 || fb[5] !== 2'd0) begin bad++; $display("FAIL arst_out got=%b/%b/%b/%0d exp=0000/0000/0000/0", oval[5], ox[5], oz[5], fb[5]); end
        total++; if (ov[0] !== 1'b0 || cnt[0] !== 8'd0 || rdy[0] !== 1'b1) begin bad++; $display("FAIL arst_tri got=%b/%0d/%b exp=0/0/1", ov[0], cnt[0], rdy[0]); end
    endtask

    initial begin
        test_reset();
        test_s1_single();
        test_s2_conflict();
        test_s3_undriven();
        test_s4_wired();
        test_backpressure();
        test_clear();
        test_saturate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/net_resolver.md
# net_resolver

Parametrised, registered resolver for multi-driven nets. It takes N_DRV per-bit-enabled drivers and resolves them per bit under a selectable net kind (tri, wor, wand, tri0, tri1) into a 3-plane result (value/x/z). The result is offered on a valid/ready output register. It is the clocked, checkable generalisation of single-kind multi-driven assigns and sits between driver-model generators and the net-checking scoreboard.

## Interface
- WIDTH, 8, bits per net.
- N_DRV, 4, number of drivers (≥1).
- MODE, RES_TRI, resolution kind (`res_mode_e`).
- CNT_W, 8, conflict counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  drivers sample is offered.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- drv_en  in  N_DRV×WIDTH  per-driver, per-bit drive enable (0 = driver is z on that bit).
- drv_val  in  N_DRV×WIDTH  per-driver value.
- out_valid  out  1  result register holds data.
- out_ready  in  1  consumer takes the result.
- out_val  out  WIDTH  resolved value (0 where x or z).
- out_x  out  WIDTH  bit is x (contention).
- out_z  out  WIDTH  bit is z (undriven).
- cnt_clr  in  1  synchronous clear of the conflict statistics.
- conflict_cnt  out  CNT_W  saturating count of accepted samples with any x bit.
- first_vld  out  1  a conflict has been captured since the last clear.
- first_bit  out  $clog2(WIDTH)  lowest conflicting bit index of the first captured conflict.

## Operation
Per-bit resolution uses k = number of enabled drivers on the bit.
- RES_TRI: if k=0, the bit is z. If all enabled values are equal, the bit is that value. Otherwise the bit is x.
- RES_TRI0 / RES_TRI1: same as RES_TRI, except k=0 gives 0 or 1 respectively.
- RES_WOR: k=0 gives z. Otherwise the bit is the OR of the enabled values and is never x.
- RES_WAND: k=0 gives z. Otherwise the bit is the AND of the enabled values and is never x.
- Exactly one of {value, x, z} applies per bit. out_val is forced to 0 on x/z bits.

Output register is a 2-state FSM, EMPTY and FULL.
- EMPTY → FULL on accept.
- FULL → EMPTY on out_ready with no accept.
- FULL stays FULL on out_ready with a same-cycle accept; the new result overwrites the register.
- in_ready = !out_valid || out_ready. This is combinational, with no other path from in to out.

Statistics:
- On an accept whose result has any out_x bit, conflict_cnt increments, saturating at 2^CNT_W−1.
- If first_vld=0 at that accept, first_vld←1 and first_bit←lowest x index.
- cnt_clr zeroes the counter and first_vld. If an accept with a conflict occurs in the same cycle, the result after the edge is cnt=1, first_vld=1, first_bit=new index; the clear is applied first and the new event is counted.
- Statistics update on accept, not on drain.

## Timing
- Reset values: out_valid=0, out_val=0, out_x=0, out_z=0, conflict_cnt=0, first_vld=0, first_bit=0. in_ready=1 after reset.
- Latency: 1 cycle. A sample accepted at edge n is visible on the out_* outputs after edge n.
- Holding: out_* hold stable while out_valid && !out_ready.
- Backpressure: while FULL && !out_ready, in_ready=0 and inputs are ignored. Sample throughput is 1 per cycle while out_ready=1.
- Reset mid-transfer: the held result is discarded and the statistics are lost. No output glitch-protection is required beyond the flops.
- drv_* are sampled only on accept and may hold any value otherwise.

## Structure
- Package `net_res_pkg`:
  - `res_mode_e` enum {RES_TRI, RES_WOR, RES_WAND, RES_TRI0, RES_TRI1}.
  - `res_bit_t` struct {val, x, z}.
  - Function `res_onehot_ok` for the plane invariant.
- Sub-module `net_res_bit`: combinational resolver of one bit over N_DRV drivers, MODE as parameter, outputs `res_bit_t`. Instantiated WIDTH times by generate.
- Top holds the FSM, output register, counter and first-conflict capture. Assertions: one-hot planes; out_* stable under backpressure.

## Test plan
All scenarios use WIDTH=4, N_DRV=2, except S6.
- S1, TRI: en0=4'b1111, val0=4'b1010, en1=0 → out_val=1010, x=0000, z=0000 one cycle later; cnt=0.
- S2, TRI: en0=en1=4'b0011, val0=4'b0001, val1=4'b0011, en bits 3:2=0 → val=0001, x=0010, z=1100; cnt=1, first_bit=1.
- S3, TRI0 vs TRI1: all en=0 → out_val=0000 vs 1111, z=0000. Same with WOR → z=1111.
- S4, WOR / WAND: en both 4'b1111, val0=1100, val1=1010 → WOR val=1110, WAND val=1000, x=0000 in both.
- S5, backpressure and simultaneous events:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out stable.
  - Then out_ready=1 → drain and accept in the same edge.
  - Pulse cnt_clr together with a conflicting accept → cnt=1, first_vld=1.
- S6, CNT_W=2: 5 conflicting accepts → cnt saturates at 3. Assert rst_n low mid-stream → all outputs at reset values immediately.
